// File: rtl/product_accumulator.sv
// product_accumulator
//   Sums a frame of unsigned products (one per valid cycle, frame closed by
//   product_last or by reaching MAX_TERMS terms) into a wide accumulator and
//   posts each finished {sum, term count} through a 2-entry output buffer with
//   a valid/ready handshake. The input side has no backpressure, so a frame
//   that closes while the buffer is full (and nothing pops) is dropped.
//
// Ports
//   clock          rising-edge clock
//   reset          asynchronous, active-low reset
//   clear          synchronous flush of frame, buffer and sticky flags
//   product        unsigned product (PRODUCT_WIDTH)
//   product_valid  product is valid this cycle
//   product_last   final term of the frame (qualified by product_valid)
//   sum            head-of-buffer frame sum (ACCUM_WIDTH)
//   sum_terms      term count of the head-of-buffer sum (COUNT_WIDTH)
//   sum_valid      buffer non-empty
//   sum_ready      consumer accepts the head entry
//   buffer_count   entries held (0..2)
//   overflow       sticky: some frame carried out of ACCUM_WIDTH
//   dropped        sticky: some frame discarded because the buffer was full
//   overlength     sticky: some frame force-closed at MAX_TERMS
//
// Build option
//   PRODUCT_ACCUMULATOR_SATURATE_EN: when defined, a carry-out clamps the
//   accumulator to all-ones for the rest of the frame; otherwise it wraps.

module product_accumulator #(
  parameter int PRODUCT_WIDTH = 36,
  parameter int ACCUM_WIDTH   = 48,
  parameter int MAX_TERMS     = 256,
  parameter int COUNT_WIDTH   = $clog2(MAX_TERMS) + 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic [PRODUCT_WIDTH-1:0] product,
  input  logic                     product_valid,
  input  logic                     product_last,
  output logic [ACCUM_WIDTH-1:0]   sum,
  output logic [COUNT_WIDTH-1:0]   sum_terms,
  output logic                     sum_valid,
  input  logic                     sum_ready,
  output logic [1:0]               buffer_count,
  output logic                     overflow,
  output logic                     dropped,
  output logic                     overlength
);

  localparam logic [COUNT_WIDTH-1:0] MAX_COUNT = COUNT_WIDTH'(MAX_TERMS);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                   state_reg, state_next;
  logic [ACCUM_WIDTH-1:0]   acc_reg, acc_next;
  logic [COUNT_WIDTH-1:0]   count_reg, count_next;
  logic [ACCUM_WIDTH:0]     add_wide;
  logic                     carry;
  logic                     frame_close;
  logic                     forced_close;

  // Buffer: slot 0 is always the head; a pop shifts slot 1 down.
  logic [ACCUM_WIDTH-1:0]   buf_sum_reg   [2];
  logic [COUNT_WIDTH-1:0]   buf_terms_reg [2];
  logic [1:0]               fill_reg, fill_next;
  logic                     pop;
  logic                     push_ok;
  logic                     push_drop;
  logic                     wr_slot;

  logic                     overflow_reg;
  logic                     dropped_reg;
  logic                     overlength_reg;

  // Frame accumulation: in IDLE the first term loads rather than adds, so the
  // stale accumulator from the previous frame is never used.
  always_comb begin
    state_next   = state_reg;
    acc_next     = acc_reg;
    count_next   = count_reg;
    carry        = 1'b0;
    frame_close  = 1'b0;
    forced_close = 1'b0;
    add_wide     = {1'b0, ((state_reg == IDLE) ? {ACCUM_WIDTH{1'b0}} : acc_reg)}
                 + {{(ACCUM_WIDTH + 1 - PRODUCT_WIDTH){1'b0}}, product};
    if (product_valid) begin
      count_next = (state_reg == IDLE) ? COUNT_WIDTH'(1) : count_reg + COUNT_WIDTH'(1);
      carry      = add_wide[ACCUM_WIDTH];
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
      // Once clamped at all-ones, any further non-zero term carries again,
      // so the clamp persists to the end of the frame without extra state.
      acc_next   = carry ? {ACCUM_WIDTH{1'b1}} : add_wide[ACCUM_WIDTH-1:0];
`else
      acc_next   = add_wide[ACCUM_WIDTH-1:0];
`endif
      frame_close  = product_last || (count_next == MAX_COUNT);
      forced_close = !product_last && (count_next == MAX_COUNT);
      state_next   = frame_close ? IDLE : ACCUM;
    end
  end

  // Buffer control: a push while full is accepted only when the head pops in
  // the same cycle.
  always_comb begin
    pop       = (fill_reg != 2'd0) && sum_ready;
    push_ok   = frame_close && ((fill_reg != 2'd2) || pop);
    push_drop = frame_close && (fill_reg == 2'd2) && !pop;
    wr_slot   = (fill_reg == 2'd2) || ((fill_reg == 2'd1) && !pop);
    fill_next = fill_reg;
    if (push_ok && !pop) begin
      fill_next = fill_reg + 2'd1;
    end else if (pop && !push_ok) begin
      fill_next = fill_reg - 2'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      count_reg <= '0;
    end else if (clear) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        buf_sum_reg[i]   <= '0;
        buf_terms_reg[i] <= '0;
      end
      fill_reg <= 2'd0;
    end else if (clear) begin
      for (int i = 0; i < 2; i++) begin
        buf_sum_reg[i]   <= '0;
        buf_terms_reg[i] <= '0;
      end
      fill_reg <= 2'd0;
    end else begin
      if (pop) begin
        buf_sum_reg[0]   <= buf_sum_reg[1];
        buf_terms_reg[0] <= buf_terms_reg[1];
      end
      // Later assignment wins when the new entry lands in slot 0.
      if (push_ok) begin
        if (wr_slot) begin
          buf_sum_reg[1]   <= acc_next;
          buf_terms_reg[1] <= count_next;
        end else begin
          buf_sum_reg[0]   <= acc_next;
          buf_terms_reg[0] <= count_next;
        end
      end
      fill_reg <= fill_next;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow_reg   <= 1'b0;
      dropped_reg    <= 1'b0;
      overlength_reg <= 1'b0;
    end else if (clear) begin
      overflow_reg   <= 1'b0;
      dropped_reg    <= 1'b0;
      overlength_reg <= 1'b0;
    end else begin
      if (carry)        overflow_reg   <= 1'b1;
      if (push_drop)    dropped_reg    <= 1'b1;
      if (forced_close) overlength_reg <= 1'b1;
    end
  end

  assign sum          = buf_sum_reg[0];
  assign sum_terms    = buf_terms_reg[0];
  assign sum_valid    = (fill_reg != 2'd0);
  assign buffer_count = fill_reg;
  assign overflow     = overflow_reg;
  assign dropped      = dropped_reg;
  assign overlength   = overlength_reg;

endmodule

// File: tb/tb_product_accumulator.sv
// Testbench for product_accumulator: a default-sized instance checked with a
// vector table, plus a narrow instance (8-bit sum, 4-term frames) checked with
// hand sequences and a randomized run against a frame-level reference model.
module tb_product_accumulator;

`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic        clear;
  logic [35:0] product;
  logic        product_valid;
  logic        product_last;
  logic        sum_ready;

  logic [47:0] m_sum;
  logic [8:0]  m_terms;
  logic        m_valid;
  logic [1:0]  m_count;
  logic        m_ovf, m_drop, m_olen;

  logic [7:0]  s_sum;
  logic [2:0]  s_terms;
  logic        s_valid;
  logic [1:0]  s_count;
  logic        s_ovf, s_drop, s_olen;

  int n_cmp = 0;
  int n_bad = 0;

  product_accumulator dut_main (
    .clock(clock), .reset(reset), .clear(clear), .product(product),
    .product_valid(product_valid), .product_last(product_last),
    .sum(m_sum), .sum_terms(m_terms), .sum_valid(m_valid), .sum_ready(sum_ready),
    .buffer_count(m_count), .overflow(m_ovf), .dropped(m_drop), .overlength(m_olen)
  );

  product_accumulator #(.PRODUCT_WIDTH(8), .ACCUM_WIDTH(8), .MAX_TERMS(4)) dut_small (
    .clock(clock), .reset(reset), .clear(clear), .product(product[7:0]),
    .product_valid(product_valid), .product_last(product_last),
    .sum(s_sum), .sum_terms(s_terms), .sum_valid(s_valid), .sum_ready(sum_ready),
    .buffer_count(s_count), .overflow(s_ovf), .dropped(s_drop), .overlength(s_olen)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int v, input int l, input int p, input int r, input int c);
    product_valid = v[0];
    product_last  = l[0];
    product       = 36'(p);
    sum_ready     = r[0];
    clear         = c[0];
  endtask

  // ---------------- vector table for the default-sized instance ----------------
  typedef struct {
    logic        v, l, r, c;
    logic [35:0] p;
    logic        ev;
    logic [47:0] es;
    logic [8:0]  et;
    logic [1:0]  ecnt;
    logic        edrop;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input int v, input int l, input int p, input int r, input int c,
                         input int ev, input int es, input int et, input int ecnt, input int edrop);
    vec_t x;
    x.v = v[0]; x.l = l[0]; x.p = 36'(p); x.r = r[0]; x.c = c[0];
    x.ev = ev[0]; x.es = 48'(es); x.et = 9'(et); x.ecnt = ecnt[1:0]; x.edrop = edrop[0];
    vecs.push_back(x);
  endtask

  // ---------------- frame-level reference model for the narrow instance ---------
  localparam int SMAX = 4;
  localparam int SLIM = 256;

  typedef struct {
    int s;
    int t;
  } ent_t;

  ent_t ref_q[$];
  int   ref_run;
  int   ref_cnt;
  bit   ref_ovf, ref_drop, ref_olen;

  task automatic model_reset();
    ref_q.delete();
    ref_run = 0; ref_cnt = 0;
    ref_ovf = 0; ref_drop = 0; ref_olen = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    ent_t e;
    if (clear) begin
      model_reset();
      return;
    end
    if (ref_q.size() > 0 && sum_ready) void'(ref_q.pop_front());
    if (product_valid) begin
      ref_run += int'(product[7:0]);
      ref_cnt++;
      if (ref_run >= SLIM) ref_ovf = 1;
      if (product_last || ref_cnt == SMAX) begin
        if (!product_last) ref_olen = 1;
        e.s = SAT ? ((ref_run >= SLIM) ? SLIM - 1 : ref_run) : (ref_run % SLIM);
        e.t = ref_cnt;
        if (ref_q.size() < 2) ref_q.push_back(e);
        else ref_drop = 1;
        ref_run = 0;
        ref_cnt = 0;
      end
    end
  endtask

  task automatic compare_small(input string tag);
    check({tag, " valid"}, 64'(s_valid), 64'(ref_q.size() > 0));
    check({tag, " count"}, 64'(s_count), 64'(ref_q.size()));
    if (ref_q.size() > 0) begin
      check({tag, " sum"}, 64'(s_sum), 64'(ref_q[0].s));
      check({tag, " terms"}, 64'(s_terms), 64'(ref_q[0].t));
    end
    check({tag, " overflow"}, 64'(s_ovf), 64'(ref_ovf));
    check({tag, " dropped"}, 64'(s_drop), 64'(ref_drop));
    check({tag, " overlength"}, 64'(s_olen), 64'(ref_olen));
  endtask

  initial begin
    int b;
    reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    model_reset();

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("reset main valid", 64'(m_valid), 64'd0);
    check("reset main count", 64'(m_count), 64'd0);
    check("reset main sum", 64'(m_sum), 64'd0);
    check("reset main flags", 64'({m_ovf, m_drop, m_olen}), 64'd0);
    check("reset small sum", 64'(s_sum), 64'd0);
    reset = 1'b1;
    step();

    // Table: 3-term frame, 1-term frame, gapped frame, buffer fill/drop,
    // full-buffer push+pop, clear discarding an in-flight product.
    add_vec(1,0,3,1,0,   0,0,0,0,0);
    add_vec(1,0,5,1,0,   0,0,0,0,0);
    add_vec(1,1,7,1,0,   1,15,3,1,0);
    add_vec(0,0,0,1,0,   0,0,0,0,0);
    add_vec(1,1,42,1,0,  1,42,1,1,0);
    add_vec(1,0,10,1,0,  0,0,0,0,0);
    add_vec(0,0,0,1,0,   0,0,0,0,0);
    add_vec(1,0,20,1,0,  0,0,0,0,0);
    add_vec(0,0,0,1,0,   0,0,0,0,0);
    add_vec(1,1,30,1,0,  1,60,3,1,0);
    add_vec(0,0,0,1,0,   0,0,0,0,0);
    add_vec(1,0,1,0,0,   0,0,0,0,0);
    add_vec(1,1,1,0,0,   1,2,2,1,0);
    add_vec(1,1,2,0,0,   1,2,2,2,0);
    add_vec(1,1,4,0,0,   1,2,2,2,1);
    add_vec(0,0,0,1,0,   1,2,1,1,1);
    add_vec(0,0,0,1,0,   0,0,0,0,1);
    add_vec(0,0,0,0,1,   0,0,0,0,0);
    add_vec(1,1,5,0,0,   1,5,1,1,0);
    add_vec(1,1,6,0,0,   1,5,1,2,0);
    add_vec(1,1,7,1,0,   1,6,1,2,0);
    add_vec(0,0,0,1,0,   1,7,1,1,0);
    add_vec(0,0,0,1,0,   0,0,0,0,0);
    add_vec(1,0,9,1,0,   0,0,0,0,0);
    add_vec(1,1,100,1,1, 0,0,0,0,0);
    add_vec(1,1,1,1,0,   1,1,1,1,0);
    add_vec(0,0,0,1,0,   0,0,0,0,0);

    foreach (vecs[i]) begin
      product_valid = vecs[i].v;
      product_last  = vecs[i].l;
      product       = vecs[i].p;
      sum_ready     = vecs[i].r;
      clear         = vecs[i].c;
      step();
      $display("row %0d: valid=%0d sum=%0d terms=%0d count=%0d dropped=%0d",
               i, m_valid, m_sum, m_terms, m_count, m_drop);
      check($sformatf("row%0d valid", i), 64'(m_valid), 64'(vecs[i].ev));
      check($sformatf("row%0d count", i), 64'(m_count), 64'(vecs[i].ecnt));
      check($sformatf("row%0d dropped", i), 64'(m_drop), 64'(vecs[i].edrop));
      if (vecs[i].ev) begin
        check($sformatf("row%0d sum", i), 64'(m_sum), 64'(vecs[i].es));
        check($sformatf("row%0d terms", i), 64'(m_terms), 64'(vecs[i].et));
      end
    end

    // Narrow instance: 200 + 100 overflows an 8-bit sum.
    drive(0, 0, 0, 1, 1); step();
    drive(1, 0, 200, 1, 0); step();
    drive(1, 1, 100, 1, 0); step();
    $display("ovf frame: sum=%0d terms=%0d overflow=%0d", s_sum, s_terms, s_ovf);
    check("ovf valid", 64'(s_valid), 64'd1);
    check("ovf sum", 64'(s_sum), SAT ? 64'd255 : 64'd44);
    check("ovf terms", 64'(s_terms), 64'd2);
    check("ovf flag", 64'(s_ovf), 64'd1);
    drive(0, 0, 0, 1, 0); step();

    // Forced close at 4 terms, then a 2-term frame ending on term 6.
    drive(0, 0, 0, 1, 1); step();
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 1, 1, 0); step();
    end
    $display("forced frame: sum=%0d terms=%0d overlength=%0d", s_sum, s_terms, s_olen);
    check("force valid", 64'(s_valid), 64'd1);
    check("force sum", 64'(s_sum), 64'd4);
    check("force terms", 64'(s_terms), 64'd4);
    check("force overlength", 64'(s_olen), 64'd1);
    drive(1, 0, 1, 1, 0); step();
    drive(1, 1, 1, 1, 0); step();
    $display("tail frame: sum=%0d terms=%0d", s_sum, s_terms);
    check("tail valid", 64'(s_valid), 64'd1);
    check("tail sum", 64'(s_sum), 64'd2);
    check("tail terms", 64'(s_terms), 64'd2);

    // Asynchronous reset mid-frame with an entry still buffered.
    drive(1, 0, 1, 0, 0); step();
    #2 reset = 1'b0;
    #1;
    $display("async reset: valid=%0d count=%0d sum=%0d", s_valid, s_count, s_sum);
    check("areset small outputs", 64'({s_sum, s_terms, s_valid, s_count, s_ovf, s_drop, s_olen}), 64'd0);
    check("areset main outputs", 64'({m_valid, m_count, m_ovf, m_drop, m_olen}), 64'd0);
    step();
    reset = 1'b1;
    drive(1, 1, 3, 0, 0); step();
    check("post reset sum", 64'(s_sum), 64'd3);
    check("post reset terms", 64'(s_terms), 64'd1);

    // Randomized run on the narrow instance.
    drive(0, 0, 0, 0, 1);
    model_step();
    step();
    compare_small("rand start");
    for (int n = 0; n < 3000; n++) begin
      b = ($urandom_range(0, 1) == 0) ? $urandom_range(128, 255) : $urandom_range(0, 40);
      drive(($urandom_range(0, 3) != 0) ? 1 : 0,
            ($urandom_range(0, 3) == 0) ? 1 : 0,
            b,
            $urandom_range(0, 1),
            ($urandom_range(0, 199) == 0) ? 1 : 0);
      if (!clear && sum_ready && ref_q.size() > 0)
        $display("rand %0d: pop sum=%0d terms=%0d", n, ref_q[0].s, ref_q[0].t);
      model_step();
      step();
      compare_small($sformatf("rand%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
